i2c_slave: RTL and testbench
============================

# i2c_slave

I2C target (responder) that answers a bus initiator at a fixed 7-bit address. It bridges the bus to two standard FIFO method ports: received bytes are pushed into an RX FIFO through its enqueue method, and transmitted bytes are pulled from a TX FIFO through its dequeue method. It sits between the board-level open-drain pads and the `fifo` instances in the I2C subsystem.

## Interface
- `p_ADDR`, 7'h42: 7-bit target address.
- `p_WORD_LEN`, 8: FIFO word width. Only 8 is legal.
- `i_clk`  in  1: system clock. Must run at ≥ 10× the SCL rate.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_scl`  in  1: SCL pad input (asynchronous).
- `i_sda`  in  1: SDA pad input (asynchronous).
- `o_sda_oe`  out  1: when 1, pull SDA low; when 0, release SDA.
- `o_scl_oe`  out  1: when 1, pull SCL low (clock stretch). Held 0 without `I2C_SLAVE_CLK_STRETCH_EN`.
- `rx_enq_data`  out  8: byte offered to the RX FIFO.
- `rx_enq_en`  out  1: one-cycle enqueue pulse.
- `rx_enq_rdy`  in  1: RX FIFO not full.
- `tx_deq_data`  in  8: TX FIFO output. Valid on the cycle after `tx_deq_en`.
- `tx_deq_en`  out  1: one-cycle dequeue pulse.
- `tx_deq_rdy`  in  1: TX FIFO not empty.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer followed by an edge register. This produces `scl_rise`, `scl_fall` and a filtered `sda`.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high.
  - Both are detected in every state and take priority over all other transitions.
  - START or repeated START: go to ADDR and clear the bit counter.
  - STOP: go to IDLE and release SDA and SCL. A partially shifted byte is discarded.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB first, sampling on `scl_rise`.
    - If the address matches `p_ADDR`, go to ADDR_ACK.
    - If it does not match, go to IGNORE.
  - IGNORE: stay until START or STOP.
  - ADDR_ACK: drive SDA low from the next `scl_fall` until the following `scl_fall`.
    - R/W=0 → WR_DATA.
    - R/W=1 → RD_DATA. The first byte is fetched at the ACK `scl_rise`.
  - WR_DATA: shift 8 bits. At the 8th `scl_rise`:
    - If `rx_enq_rdy`, pulse `rx_enq_en` with the byte and go to WR_ACK, which drives ACK.
    - If not `rx_enq_rdy`, the byte is dropped and WR_ACK releases SDA (NACK).
    - After WR_ACK, return to WR_DATA.
  - RD_DATA: on each `scl_fall`, drive `o_sda_oe = ~bit` (MSB first). After the 8th bit, release SDA and go to RD_ACK.
  - RD_ACK: sample the initiator's ACK at `scl_rise`.
    - ACK (SDA=0): fetch the next byte and go to RD_DATA.
    - NACK: go to IGNORE.
  - Fetch:
    - If `tx_deq_rdy`, pulse `tx_deq_en` and load the shift register from `tx_deq_data` one cycle later.
    - If empty, load 8'hFF.
- Reset value of every output is 0, and the state is IDLE.
- Reset asserted mid-transfer releases both lines immediately (asynchronous).

## Timing
- Input-to-detect latency is 3 `i_clk` cycles.
- SDA changes occur 1 cycle after the detected `scl_fall`, which is well inside SCL low.
- `rx_enq_en` fires exactly once per accepted byte, 1 cycle after the 8th detected `scl_rise`.
- `tx_deq_en` fires exactly once per byte transmitted. The shift register loads 1 cycle later and is always ready before the next `scl_fall`.
- A START or STOP arriving on the same cycle as an `scl` edge takes precedence. No enqueue or dequeue is issued for that edge.

## Configuration
- `I2C_SLAVE_CLK_STRETCH_EN` defined:
  - WR_DATA with the RX FIFO full: hold `o_scl_oe=1` from the 8th-bit `scl_fall`. When `rx_enq_rdy` rises, enqueue, drive ACK, then release SCL. No NACK is ever sent for a full FIFO.
  - Fetch with the TX FIFO empty: hold SCL low from the next `scl_fall` until `tx_deq_rdy`, dequeue, load the byte, drive the MSB, then release SCL.
  - STOP, START or reset always releases SCL.
- Not defined: `o_scl_oe` is tied to 0. A full RX FIFO causes NACK with the byte dropped. An empty TX FIFO causes 8'hFF to be sent.

## Structure
- Package `i2c_pkg` holds the state encoding (IDLE, ADDR, ADDR_ACK, IGNORE, WR_DATA, WR_ACK, RD_DATA, RD_ACK), the R/W bit constants, and the 7-bit address width.
- One sub-module, `i2c_line_sync`: a 2-FF synchronizer plus rise/fall detect for a single line, instantiated twice (SCL and SDA).

## Test plan
- Write 0x84 (addr 0x42, W), then 0xA5, 0x3C, then STOP → 2 `rx_enq_en` pulses carrying 0xA5, 0x3C. ACK on all 3 bytes.
- Address 0x43 W followed by data → no ACK, no enqueue, `o_sda_oe` stays 0 until STOP.
- TX FIFO holds 0x11, 0x22. Read 0x85, initiator ACKs then NACKs → bus carries 0x11, 0x22. Exactly 2 `tx_deq_en` pulses.
- RX FIFO full, write 0x55 → without macro: NACK, no `rx_enq_en`. With macro: SCL held low until `rx_enq_rdy`, then ACK and 0x55 enqueued.
- Repeated START mid-write byte (after 4 bits), then read → partial byte discarded, correct ADDR_ACK, read proceeds.
- Reset pulsed while driving a read bit low → `o_sda_oe`/`o_scl_oe` go 0 asynchronously. IDLE after release, no spurious FIFO pulses.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C target.
//   - FSM state encoding (3-bit localparams)
//   - R/W bit values, address width
//   - line_t: synchronized level plus edge strobes for one bus line
//   - I2C_SLAVE_CLK_STRETCH_EN (optional, read by i2c_slave): enables SCL stretching
package i2c_pkg;

   localparam int ADDR_W = 7;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ADDR     = 3'd1;
   localparam logic [2:0] S_ADDR_ACK = 3'd2;
   localparam logic [2:0] S_IGNORE   = 3'd3;
   localparam logic [2:0] S_WR_DATA  = 3'd4;
   localparam logic [2:0] S_WR_ACK   = 3'd5;
   localparam logic [2:0] S_RD_DATA  = 3'd6;
   localparam logic [2:0] S_RD_ACK   = 3'd7;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef struct packed {
      logic lvl;
      logic rise;
      logic fall;
   } line_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: 2-FF synchronizer plus edge register for one open-drain line.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_line         : raw pad input (asynchronous)
//   o_line         : synchronized level with one-cycle rise/fall strobes
// Registers reset to 1 (idle bus level) so reset release never fakes an edge.
module i2c_line_sync
   import i2c_pkg::*;
(
   input  logic  i_clk,
   input  logic  i_rst_n,
   input  logic  i_line,
   output line_t o_line
);

   // [0] metastable stage, [1] synchronized level, [2] previous level
   logic [2:0] r_pipe;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_pipe <= 3'b111;
      else          r_pipe <= {r_pipe[1:0], i_line};
   end

   assign o_line.lvl  = r_pipe[1];
   assign o_line.rise = r_pipe[1] & ~r_pipe[2];
   assign o_line.fall = ~r_pipe[1] & r_pipe[2];

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target at a fixed 7-bit address, bridging to RX/TX FIFO ports.
//   i_clk, i_rst_n            : system clock (>= 10x SCL), async active-low reset
//   i_scl, i_sda              : pad inputs (asynchronous)
//   o_sda_oe, o_scl_oe        : open-drain pull-low enables
//   rx_enq_data/en, rx_enq_rdy: RX FIFO enqueue port
//   tx_deq_data/en, tx_deq_rdy: TX FIFO dequeue port (data valid the cycle after en)
// Optional macro I2C_SLAVE_CLK_STRETCH_EN: stretch SCL instead of NACKing a full
// RX FIFO or sending 8'hFF from an empty TX FIFO. Without it o_scl_oe stays 0.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] p_ADDR     = 7'h42,
   parameter int                p_WORD_LEN = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_scl,
   input  logic                  i_sda,
   output logic                  o_sda_oe,
   output logic                  o_scl_oe,
   output logic [p_WORD_LEN-1:0] rx_enq_data,
   output logic                  rx_enq_en,
   input  logic                  rx_enq_rdy,
   input  logic [p_WORD_LEN-1:0] tx_deq_data,
   output logic                  tx_deq_en,
   input  logic                  tx_deq_rdy
);

   localparam int W = p_WORD_LEN;
   localparam logic [3:0] LAST_BIT = 4'(W - 1);
   localparam logic [3:0] ALL_BITS = 4'(W);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
   localparam bit STRETCH = 1'b1;
`else
   localparam bit STRETCH = 1'b0;
`endif

   line_t          w_scl, w_sda;
   logic           w_start, w_stop, w_last, w_tx_busy, w_fetch;
   logic [W-1:0]   w_byte;

   logic [2:0]     r_state;
   logic [3:0]     r_bitcnt;
   logic [W-1:0]   r_shift, r_rx_data;
   logic           r_rw, r_ack, r_sda_oe, r_scl_oe;
   logic           r_rx_en, r_tx_en, r_load;
   logic           r_wait_rx, r_wait_tx, r_hold;

   i2c_line_sync u_scl_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_scl), .o_line(w_scl));
   i2c_line_sync u_sda_sync (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(i_sda), .o_line(w_sda));

   assign w_start   = w_sda.fall & w_scl.lvl;
   assign w_stop    = w_sda.rise & w_scl.lvl;
   assign w_byte    = {r_shift[W-2:0], w_sda.lvl};
   assign w_last    = (r_bitcnt == LAST_BIT);
   // Shift register not yet holding the next TX byte.
   assign w_tx_busy = r_wait_tx | r_tx_en | r_load;
   // Fetch points: ACK clock of a read address, and an initiator ACK in RD_ACK.
   assign w_fetch   = w_scl.rise & ~w_start & ~w_stop &
                      (((r_state == S_ADDR_ACK) & (r_bitcnt == 4'd1) & (r_rw == RW_READ)) |
                       ((r_state == S_RD_ACK) & ~w_sda.lvl));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_rx_data <= '0;
         r_rw      <= 1'b0;
         r_ack     <= 1'b0;
         r_sda_oe  <= 1'b0;
         r_scl_oe  <= 1'b0;
         r_rx_en   <= 1'b0;
         r_tx_en   <= 1'b0;
         r_load    <= 1'b0;
         r_wait_rx <= 1'b0;
         r_wait_tx <= 1'b0;
         r_hold    <= 1'b0;
      end else begin
         r_rx_en <= 1'b0;
         r_tx_en <= 1'b0;
         // FIFO data is valid the cycle after the dequeue pulse
         r_load  <= r_tx_en;
         if (r_load) r_shift <= tx_deq_data;

         if (w_start || w_stop) begin
            r_state   <= w_start ? S_ADDR : S_IDLE;
            r_bitcnt  <= '0;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_wait_rx <= 1'b0;
            r_wait_tx <= 1'b0;
            r_hold    <= 1'b0;
         end else begin
            // Stretch resolution: only reachable when STRETCH sets the wait flags.
            if (r_wait_tx && tx_deq_rdy) begin
               r_tx_en   <= 1'b1;
               r_wait_tx <= 1'b0;
            end
            if (r_wait_rx && rx_enq_rdy) begin
               r_rx_en   <= 1'b1;
               r_ack     <= 1'b1;
               r_wait_rx <= 1'b0;
            end
            if (r_hold) begin
               // SCL is held low: do the deferred SDA update, release SCL next cycle.
               if (r_state == S_WR_ACK && !r_wait_rx) begin
                  r_sda_oe <= r_ack;
                  r_bitcnt <= 4'd1;
                  r_hold   <= 1'b0;
               end else if (r_state == S_RD_DATA && !w_tx_busy) begin
                  r_sda_oe <= ~r_shift[W-1];
                  r_shift  <= {r_shift[W-2:0], 1'b0};
                  r_bitcnt <= 4'd1;
                  r_hold   <= 1'b0;
               end
            end else if (r_scl_oe) begin
               r_scl_oe <= 1'b0;
            end

            case (r_state)
               S_ADDR: if (w_scl.rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (w_last) begin
                     r_bitcnt <= '0;
                     r_rw     <= w_sda.lvl;
                     r_state  <= (w_byte[W-1:1] == p_ADDR) ? S_ADDR_ACK : S_IGNORE;
                  end
               end
               S_ADDR_ACK: if (w_scl.fall) begin
                  if (r_bitcnt == 4'd0) begin
                     r_sda_oe <= 1'b1;
                     r_bitcnt <= 4'd1;
                  end else if (r_rw == RW_WRITE) begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= S_WR_DATA;
                  end else begin
                     r_state <= S_RD_DATA;
                     if (STRETCH && w_tx_busy) begin
                        r_hold   <= 1'b1;
                        r_scl_oe <= 1'b1;
                        r_bitcnt <= '0;
                     end else begin
                        // ACK ends and the MSB goes out on the same falling edge
                        r_sda_oe <= ~r_shift[W-1];
                        r_shift  <= {r_shift[W-2:0], 1'b0};
                        r_bitcnt <= 4'd1;
                     end
                  end
               end
               S_WR_DATA: if (w_scl.rise) begin
                  r_shift  <= w_byte;
                  r_bitcnt <= r_bitcnt + 4'd1;
                  if (w_last) begin
                     r_bitcnt  <= '0;
                     r_rx_data <= w_byte;
                     r_state   <= S_WR_ACK;
                     r_ack     <= rx_enq_rdy;
                     if (rx_enq_rdy)   r_rx_en   <= 1'b1;
                     else if (STRETCH) r_wait_rx <= 1'b1;
                  end
               end
               S_WR_ACK: if (w_scl.fall) begin
                  if (r_bitcnt == 4'd0) begin
                     if (STRETCH && r_wait_rx) begin
                        r_hold   <= 1'b1;
                        r_scl_oe <= 1'b1;
                     end else begin
                        r_sda_oe <= r_ack;
                        r_bitcnt <= 4'd1;
                     end
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= S_WR_DATA;
                  end
               end
               S_RD_DATA: if (w_scl.fall) begin
                  if (r_bitcnt == ALL_BITS) begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= S_RD_ACK;
                  end else if (STRETCH && r_bitcnt == 4'd0 && w_tx_busy) begin
                     r_hold   <= 1'b1;
                     r_scl_oe <= 1'b1;
                  end else begin
                     r_sda_oe <= ~r_shift[W-1];
                     r_shift  <= {r_shift[W-2:0], 1'b0};
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end
               end
               S_RD_ACK: if (w_scl.rise) begin
                  r_bitcnt <= '0;
                  r_state  <= w_sda.lvl ? S_IGNORE : S_RD_DATA;
               end
               default: ;
            endcase

            if (w_fetch) begin
               if (tx_deq_rdy)   r_tx_en   <= 1'b1;
               else if (STRETCH) r_wait_tx <= 1'b1;
               else              r_shift   <= '1;
            end
         end
      end
   end

   assign o_sda_oe    = r_sda_oe;
   assign o_scl_oe    = r_scl_oe;
   assign rx_enq_data = r_rx_data;
   assign rx_enq_en   = r_rx_en;
   assign tx_deq_en   = r_tx_en;

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bench for i2c_slave. Bit-banged initiator on a
// wired-AND bus, simple RX capture log and TX FIFO model.
module tb_i2c_slave;

   localparam time T = 100ns;   // quarter SCL period, 40 i_clk per SCL cycle

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_scl = 1'b1, m_sda = 1'b1;
   logic       scl_bus, sda_bus;
   logic       o_sda_oe, o_scl_oe;
   logic [7:0] rx_enq_data;
   logic       rx_enq_en;
   logic       rx_rdy = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_deq_en, tx_rdy;

   logic [7:0] rx_log [0:15];
   logic [7:0] tx_mem [0:7];
   int         rx_n = 0, deq_cnt = 0, sda_cnt = 0, tx_rd = 0, tx_wr = 0;
   int         n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   assign scl_bus = m_scl & ~o_scl_oe;
   assign sda_bus = m_sda & ~o_sda_oe;
   assign tx_rdy  = (tx_rd != tx_wr);

   i2c_slave dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl_bus), .i_sda(sda_bus),
      .o_sda_oe(o_sda_oe), .o_scl_oe(o_scl_oe),
      .rx_enq_data(rx_enq_data), .rx_enq_en(rx_enq_en), .rx_enq_rdy(rx_rdy),
      .tx_deq_data(tx_data), .tx_deq_en(tx_deq_en), .tx_deq_rdy(tx_rdy)
   );

   always @(posedge clk) begin
      if (rx_enq_en) begin
         rx_log[rx_n % 16] <= rx_enq_data;
         rx_n <= rx_n + 1;
      end
      if (tx_deq_en) begin
         tx_data <= tx_mem[tx_rd % 8];
         tx_rd   <= tx_rd + 1;
         deq_cnt <= deq_cnt + 1;
      end
      if (o_sda_oe) sda_cnt <= sda_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic scl_high();
      m_scl = 1'b1;
      for (int i = 0; i < 20000 && scl_bus !== 1'b1; i++) @(posedge clk);
      if (scl_bus !== 1'b1) check("scl_release_timeout", 32'(scl_bus), 32'd1);
   endtask

   task automatic clk_bit(input logic b, output logic r);
      m_sda = b; #T;
      scl_high(); #T;
      r = sda_bus; #T;
      m_scl = 1'b0; #T;
   endtask

   task automatic start_c();
      m_sda = 1'b1; #T;
      scl_high(); #T;
      m_sda = 1'b0; #T;
      m_scl = 1'b0; #T;
   endtask

   task automatic stop_c();
      m_sda = 1'b0; #T;
      scl_high(); #T;
      m_sda = 1'b1; #(2*T);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
      clk_bit(1'b1, r);
      ack = ~r;
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic r;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clk_bit(1'b1, r);
         d = {d[6:0], r};
      end
      clk_bit(~ack, r);
   endtask

   initial begin
      logic       ack;
      logic [7:0] b;
      int         exp_rx, snap;
      exp_rx = 0;

      // Reset state
      repeat (5) @(posedge clk);
      #1;
      check("rst_sda_oe", 32'(o_sda_oe), 32'd0);
      check("rst_scl_oe", 32'(o_scl_oe), 32'd0);
      check("rst_rx_en", 32'(rx_enq_en), 32'd0);
      check("rst_tx_en", 32'(tx_deq_en), 32'd0);
      check("rst_rx_data", 32'(rx_enq_data), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Write 0xA5, 0x3C to address 0x42
      start_c();
      write_byte(8'h84, ack); check("t1_addr_ack", 32'(ack), 32'd1);
      write_byte(8'hA5, ack); check("t1_d0_ack", 32'(ack), 32'd1);
      write_byte(8'h3C, ack); check("t1_d1_ack", 32'(ack), 32'd1);
      stop_c();
      exp_rx = 2;
      check("t1_rx_cnt", 32'(rx_n), 32'(exp_rx));
      check("t1_rx0", 32'(rx_log[0]), 32'hA5);
      check("t1_rx1", 32'(rx_log[1]), 32'h3C);
      check("t1_deq_cnt", 32'(deq_cnt), 32'd0);

      // Wrong address 0x43: ignored, SDA never pulled
      snap = sda_cnt;
      start_c();
      write_byte(8'h86, ack); check("t2_addr_nack", 32'(ack), 32'd0);
      write_byte(8'h77, ack); check("t2_data_nack", 32'(ack), 32'd0);
      stop_c();
      check("t2_rx_cnt", 32'(rx_n), 32'(exp_rx));
      check("t2_sda_quiet", 32'(sda_cnt - snap), 32'd0);

      // Read two bytes from TX FIFO
      tx_mem[0] = 8'h11; tx_mem[1] = 8'h22; tx_wr = 2;
      start_c();
      write_byte(8'h85, ack); check("t3_addr_ack", 32'(ack), 32'd1);
      read_byte(b, 1'b1); check("t3_rd0", 32'(b), 32'h11);
      read_byte(b, 1'b0); check("t3_rd1", 32'(b), 32'h22);
      stop_c();
      check("t3_deq_cnt", 32'(deq_cnt), 32'd2);

      // Write with RX FIFO full
      rx_rdy = 1'b0;
      start_c();
      write_byte(8'h84, ack); check("t4_addr_ack", 32'(ack), 32'd1);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      fork begin #5000ns; rx_rdy = 1'b1; end join_none
      write_byte(8'h55, ack); check("t4_stretch_ack", 32'(ack), 32'd1);
      exp_rx++;
      check("t4_rx_data", 32'(rx_log[(exp_rx-1) % 16]), 32'h55);
`else
      write_byte(8'h55, ack); check("t4_full_nack", 32'(ack), 32'd0);
`endif
      stop_c();
      rx_rdy = 1'b1;
      check("t4_rx_cnt", 32'(rx_n), 32'(exp_rx));

      // Repeated START after 4 bits of a write byte, then read
      tx_mem[2] = 8'h5A; tx_wr = 3;
      start_c();
      write_byte(8'h84, ack); check("t5_wr_addr_ack", 32'(ack), 32'd1);
      clk_bit(1'b1, ack); clk_bit(1'b0, ack); clk_bit(1'b1, ack); clk_bit(1'b0, ack);
      start_c();
      write_byte(8'h85, ack); check("t5_rd_addr_ack", 32'(ack), 32'd1);
      read_byte(b, 1'b0); check("t5_rd", 32'(b), 32'h5A);
      stop_c();
      check("t5_deq_cnt", 32'(deq_cnt), 32'd3);
      check("t5_rx_cnt", 32'(rx_n), 32'(exp_rx));

      // Reset while the target drives a 0 data bit
      tx_mem[3] = 8'h00; tx_wr = 4;
      start_c();
      write_byte(8'h85, ack); check("t6_addr_ack", 32'(ack), 32'd1);
      check("t6_driving_low", 32'(o_sda_oe), 32'd1);
      #3ns;
      rst_n = 1'b0;
      #1ns;
      check("t6_rst_sda_oe", 32'(o_sda_oe), 32'd0);
      check("t6_rst_scl_oe", 32'(o_scl_oe), 32'd0);
      repeat (3) @(posedge clk);
      rst_n = 1'b1;
      snap = sda_cnt;
      m_sda = 1'b1; #T;
      m_scl = 1'b1; #T;
      repeat (20) @(posedge clk);
      check("t6_deq_cnt", 32'(deq_cnt), 32'd4);
      check("t6_rx_cnt", 32'(rx_n), 32'(exp_rx));
      check("t6_sda_quiet", 32'(sda_cnt - snap), 32'd0);
      start_c();
      write_byte(8'h84, ack); check("t6_post_addr_ack", 32'(ack), 32'd1);
      write_byte(8'h99, ack); check("t6_post_data_ack", 32'(ack), 32'd1);
      stop_c();
      exp_rx++;
      check("t6_post_rx_cnt", 32'(rx_n), 32'(exp_rx));
      check("t6_post_rx_data", 32'(rx_log[(exp_rx-1) % 16]), 32'h99);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
